// File: rtl/controle_memoria_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | controle_memoria_if : command handshake and register-file bus  (rev 1.0) |
// +--------------------------------------------------------------------------+
interface controle_memoria_if #(
  parameter int LARGURA  = 16,
  parameter int ENDERECO = 4
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [2:0]          opcode;
  logic [ENDERECO-1:0] rd;
  logic [ENDERECO-1:0] rs1;
  logic [ENDERECO-1:0] rs2;
  logic [LARGURA-1:0]  imediato;
  logic [ENDERECO-1:0] mem_endereco_reg1;
  logic [ENDERECO-1:0] mem_endereco_reg2;
  logic [LARGURA-1:0]  mem_conteudo_reg1;
  logic [LARGURA-1:0]  mem_conteudo_reg2;
  logic [ENDERECO-1:0] mem_endereco_escrita;
  logic [LARGURA-1:0]  mem_conteudo_escrita;
  logic                mem_enable;
  logic                mem_clear;
  logic [LARGURA-1:0]  resultado;
  logic                overflow;
  logic                pronto;

  modport slave (
    input  cmd_valid, opcode, rd, rs1, rs2, imediato,
           mem_conteudo_reg1, mem_conteudo_reg2,
    output cmd_ready, mem_endereco_reg1, mem_endereco_reg2,
           mem_endereco_escrita, mem_conteudo_escrita, mem_enable, mem_clear,
           resultado, overflow, pronto
  );

  modport master (
    output cmd_valid, opcode, rd, rs1, rs2, imediato,
           mem_conteudo_reg1, mem_conteudo_reg2,
    input  cmd_ready, mem_endereco_reg1, mem_endereco_reg2,
           mem_endereco_escrita, mem_conteudo_escrita, mem_enable, mem_clear,
           resultado, overflow, pronto
  );
endinterface
`default_nettype wire

// File: rtl/controle_memoria.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | controle_memoria : command sequencer for the register file     (rev 1.0) |
// +--------------------------------------------------------------------------+
module controle_memoria #(
  parameter int LARGURA  = 16,
  parameter int ENDERECO = 4
) (
  input  logic                clk,
  input  logic                ativar_clear_n,
  controle_memoria_if.slave   bus
);

  localparam logic [2:0] OP_LOAD    = 3'b000;
  localparam logic [2:0] OP_ADD     = 3'b001;
  localparam logic [2:0] OP_ADDI    = 3'b010;
  localparam logic [2:0] OP_SUB     = 3'b011;
  localparam logic [2:0] OP_SUBI    = 3'b100;
  localparam logic [2:0] OP_MUL     = 3'b101;
  localparam logic [2:0] OP_CLEAR   = 3'b110;
  localparam logic [2:0] OP_DISPLAY = 3'b111;

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    LEITURA = 3'd1,
    EXECUTA = 3'd2,
    ESCRITA = 3'd3,
    LIMPA   = 3'd4,
    FIM     = 3'd5
  } estado_t;

  estado_t             estado;
  estado_t             proximo;

  logic                aceite;
  logic [2:0]          op_q;
  logic [ENDERECO-1:0] rd_q;
  logic [LARGURA-1:0]  imm_q;
  logic [LARGURA-1:0]  op_a;
  logic [LARGURA-1:0]  op_b;
  logic                usa_imediato;

  logic [LARGURA:0]    soma;
  logic [LARGURA:0]    diferenca;
  logic [2*LARGURA-1:0] produto;
  logic [LARGURA-1:0]  alu_res;
  logic                alu_ov;

  assign bus.cmd_ready = (estado == OCIOSO);
  assign aceite        = bus.cmd_valid && (estado == OCIOSO);
  assign usa_imediato  = (op_q == OP_ADDI) || (op_q == OP_SUBI);

  always_ff @(posedge clk or negedge ativar_clear_n) begin
    if (!ativar_clear_n) begin
      estado <= OCIOSO;
    end else begin
      estado <= proximo;
    end
  end

  always_comb begin
    proximo = estado;
    case (estado)
      OCIOSO: begin
        if (aceite) begin
          proximo = (bus.opcode == OP_CLEAR) ? LIMPA : LEITURA;
        end
      end
      LEITURA: proximo = EXECUTA;
      EXECUTA: proximo = (op_q == OP_DISPLAY) ? FIM : ESCRITA;
      ESCRITA: proximo = FIM;
      LIMPA:   proximo = FIM;
      FIM:     proximo = OCIOSO;
      default: proximo = OCIOSO;
    endcase
  end

  // Carry and borrow fall out of the extra top bit of the widened sum/difference.
  always_comb begin
    soma      = {1'b0, op_a} + {1'b0, op_b};
    diferenca = {1'b0, op_a} - {1'b0, op_b};
    produto   = {{LARGURA{1'b0}}, op_a} * {{LARGURA{1'b0}}, op_b};
    alu_res   = bus.resultado;
    alu_ov    = bus.overflow;
    case (op_q)
      OP_LOAD: begin
        alu_res = imm_q;
        alu_ov  = 1'b0;
      end
      OP_ADD, OP_ADDI: begin
        alu_res = soma[LARGURA-1:0];
        alu_ov  = soma[LARGURA];
      end
      OP_SUB, OP_SUBI: begin
        alu_res = diferenca[LARGURA-1:0];
        alu_ov  = diferenca[LARGURA];
      end
      OP_MUL: begin
        alu_res = produto[LARGURA-1:0];
        alu_ov  = |produto[2*LARGURA-1:LARGURA];
      end
      OP_DISPLAY: begin
        alu_res = op_a;
      end
      default: begin
        alu_res = bus.resultado;
      end
    endcase
  end

  // Strobes are decoded from the next state so they come straight off flops.
  always_ff @(posedge clk or negedge ativar_clear_n) begin
    if (!ativar_clear_n) begin
      op_q                     <= '0;
      rd_q                     <= '0;
      imm_q                    <= '0;
      op_a                     <= '0;
      op_b                     <= '0;
      bus.mem_endereco_reg1    <= '0;
      bus.mem_endereco_reg2    <= '0;
      bus.mem_endereco_escrita <= '0;
      bus.mem_conteudo_escrita <= '0;
      bus.mem_enable           <= 1'b0;
      bus.mem_clear            <= 1'b0;
      bus.resultado            <= '0;
      bus.overflow             <= 1'b0;
      bus.pronto               <= 1'b0;
    end else begin
      bus.mem_enable <= (proximo == ESCRITA);
      bus.mem_clear  <= (proximo == LIMPA);
      bus.pronto     <= (proximo == FIM);

      if (aceite) begin
        op_q                  <= bus.opcode;
        rd_q                  <= bus.rd;
        imm_q                 <= bus.imediato;
        bus.mem_endereco_reg1 <= bus.rs1;
        bus.mem_endereco_reg2 <= bus.rs2;
      end

      if (estado == LEITURA) begin
        op_a <= bus.mem_conteudo_reg1;
        op_b <= usa_imediato ? imm_q : bus.mem_conteudo_reg2;
      end

      if (estado == EXECUTA) begin
        bus.resultado <= alu_res;
        bus.overflow  <= alu_ov;
        if (op_q != OP_DISPLAY) begin
          bus.mem_endereco_escrita <= rd_q;
          bus.mem_conteudo_escrita <= alu_res;
        end
      end

      if (estado == LIMPA) begin
        bus.overflow <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_controle_memoria.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_controle_memoria : bench for the register-file sequencer    (rev 1.0) |
// +--------------------------------------------------------------------------+
module tb_controle_memoria;

  localparam int LARGURA  = 16;
  localparam int ENDERECO = 4;

  localparam logic [2:0] OP_LOAD    = 3'b000;
  localparam logic [2:0] OP_ADD     = 3'b001;
  localparam logic [2:0] OP_ADDI    = 3'b010;
  localparam logic [2:0] OP_SUB     = 3'b011;
  localparam logic [2:0] OP_SUBI    = 3'b100;
  localparam logic [2:0] OP_MUL     = 3'b101;
  localparam logic [2:0] OP_CLEAR   = 3'b110;
  localparam logic [2:0] OP_DISPLAY = 3'b111;

  localparam int NV       = 24;
  localparam int IDX_HOLD = 20;

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [15:0] imm;
    logic [15:0] res;
    bit          ov;
  } vec_t;

  logic clk = 1'b0;
  logic ativar_clear_n;

  controle_memoria_if #(.LARGURA(LARGURA), .ENDERECO(ENDERECO)) bus ();

  controle_memoria #(.LARGURA(LARGURA), .ENDERECO(ENDERECO)) dut (
    .clk            (clk),
    .ativar_clear_n (ativar_clear_n),
    .bus            (bus.slave)
  );

  always #5 clk = ~clk;

  // Register file: synchronous write/clear, asynchronous read, not reset.
  logic [LARGURA-1:0] banco [0:(1<<ENDERECO)-1];

  always @(posedge clk) begin
    if (bus.mem_clear) begin
      for (int i = 0; i < (1<<ENDERECO); i++) banco[i] <= '0;
    end else if (bus.mem_enable) begin
      banco[bus.mem_endereco_escrita] <= bus.mem_conteudo_escrita;
    end
  end

  assign bus.mem_conteudo_reg1 = banco[bus.mem_endereco_reg1];
  assign bus.mem_conteudo_reg2 = banco[bus.mem_endereco_reg2];

  int   compared   = 0;
  int   mismatched = 0;
  vec_t exp_q[$];
  vec_t vec [NV];

  function automatic vec_t mk(input logic [2:0] op, input logic [3:0] rd, rs1, rs2,
                              input logic [15:0] imm, res, input bit ov);
    vec_t v;
    v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.imm = imm; v.res = res; v.ov = ov;
    return v;
  endfunction

  task automatic check(input string nome, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nome, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_cmd(input int idx, input vec_t v);
    int   cyc = 0, wr_n = 0, clr_n = 0, both_n = 0, busy_rdy = 0;
    int   lat_exp;
    bit   done = 0;
    logic [3:0]  wa = '0;
    logic [15:0] wd = '0;
    vec_t e;
    exp_q.push_back(v);
    wait_ready();
    bus.opcode = v.op; bus.rd = v.rd; bus.rs1 = v.rs1; bus.rs2 = v.rs2; bus.imediato = v.imm;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    while (!done && cyc < 12) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        bus.cmd_valid = 1'b0;
        bus.opcode    = 3'($urandom);
        bus.rd        = 4'($urandom);
        bus.rs1       = 4'($urandom);
        bus.rs2       = 4'($urandom);
        bus.imediato  = 16'($urandom);
      end
      if (bus.mem_enable) begin wr_n++; wa = bus.mem_endereco_escrita; wd = bus.mem_conteudo_escrita; end
      if (bus.mem_clear) clr_n++;
      if (bus.mem_enable && bus.mem_clear) both_n++;
      if (bus.cmd_ready) busy_rdy++;
      if (bus.pronto) done = 1;
    end
    e = exp_q.pop_front();
    lat_exp = (e.op == OP_CLEAR) ? 2 : (e.op == OP_DISPLAY) ? 3 : 4;
    check($sformatf("v%0d latency", idx), done ? cyc : 32'hFFFF_FFFF, lat_exp);
    check($sformatf("v%0d write_pulses", idx), wr_n, (e.op == OP_CLEAR || e.op == OP_DISPLAY) ? 0 : 1);
    check($sformatf("v%0d clear_pulses", idx), clr_n, (e.op == OP_CLEAR) ? 1 : 0);
    check($sformatf("v%0d both_high", idx), both_n, 0);
    check($sformatf("v%0d ready_while_busy", idx), busy_rdy, 0);
    if (wr_n == 1) begin
      check($sformatf("v%0d write_addr", idx), wa, e.rd);
      check($sformatf("v%0d write_data", idx), wd, e.res);
    end
    check($sformatf("v%0d resultado", idx), bus.resultado, e.res);
    check($sformatf("v%0d overflow", idx), bus.overflow, e.ov);
  endtask

  // DISPLAY r7 with cmd_valid held: one accept per idle visit, period of 4 cycles.
  task automatic hold_test();
    int acc = 0, pr = 0, pulses = 0;
    wait_ready();
    bus.opcode = OP_DISPLAY; bus.rd = 4'd0; bus.rs1 = 4'd7; bus.rs2 = 4'd0; bus.imediato = '0;
    bus.cmd_valid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      if (bus.cmd_ready && bus.cmd_valid) acc++;
      if (bus.pronto) pr++;
      if (bus.mem_enable || bus.mem_clear) pulses++;
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("hold accepts", acc, 3);
    check("hold pronto", pr, 3);
    check("hold mem pulses", pulses, 0);
    check("hold resultado", bus.resultado, 16'hBEEF);
    check("hold overflow", bus.overflow, 1'b0);
  endtask

  task automatic reset_mid(input string nome, input logic [2:0] op);
    int pulses = 0, pr = 0, not_rdy = 0;
    wait_ready();
    bus.opcode = op; bus.rd = 4'd5; bus.rs1 = 4'd5; bus.rs2 = 4'd5; bus.imediato = 16'h1111;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    if (op == OP_CLEAR) check({nome, " clear before reset"}, bus.mem_clear, 1'b1);
    ativar_clear_n = 1'b0;
    #1;
    check({nome, " ready"}, bus.cmd_ready, 1'b1);
    check({nome, " mem_enable"}, bus.mem_enable, 1'b0);
    check({nome, " mem_clear"}, bus.mem_clear, 1'b0);
    check({nome, " pronto"}, bus.pronto, 1'b0);
    check({nome, " resultado"}, bus.resultado, 16'h0000);
    check({nome, " overflow"}, bus.overflow, 1'b0);
    repeat (2) @(negedge clk);
    ativar_clear_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.mem_enable || bus.mem_clear) pulses++;
      if (bus.pronto) pr++;
      if (!bus.cmd_ready) not_rdy++;
    end
    check({nome, " late pulses"}, pulses, 0);
    check({nome, " late pronto"}, pr, 0);
    check({nome, " idle after release"}, not_rdy, 0);
  endtask

  initial begin
    ativar_clear_n = 1'b0;
    bus.cmd_valid  = 1'b0;
    bus.opcode     = '0;
    bus.rd         = '0;
    bus.rs1        = '0;
    bus.rs2        = '0;
    bus.imediato   = '0;

    vec[0]  = mk(OP_LOAD,    4'd3,  4'd0,  4'd0,  16'h1234, 16'h1234, 1'b0);
    vec[1]  = mk(OP_LOAD,    4'd3,  4'd0,  4'd0,  16'hFFFF, 16'hFFFF, 1'b0);
    vec[2]  = mk(OP_LOAD,    4'd4,  4'd0,  4'd0,  16'h0002, 16'h0002, 1'b0);
    vec[3]  = mk(OP_ADD,     4'd5,  4'd3,  4'd4,  16'h0000, 16'h0001, 1'b1);
    vec[4]  = mk(OP_LOAD,    4'd3,  4'd0,  4'd0,  16'h0002, 16'h0002, 1'b0);
    vec[5]  = mk(OP_ADD,     4'd3,  4'd3,  4'd3,  16'h0000, 16'h0004, 1'b0);
    vec[6]  = mk(OP_LOAD,    4'd1,  4'd0,  4'd0,  16'h0003, 16'h0003, 1'b0);
    vec[7]  = mk(OP_SUBI,    4'd2,  4'd1,  4'd9,  16'h0005, 16'hFFFE, 1'b1);
    vec[8]  = mk(OP_LOAD,    4'd8,  4'd0,  4'd0,  16'h0100, 16'h0100, 1'b0);
    vec[9]  = mk(OP_MUL,     4'd9,  4'd8,  4'd8,  16'h0000, 16'h0000, 1'b1);
    vec[10] = mk(OP_LOAD,    4'd10, 4'd0,  4'd0,  16'h0003, 16'h0003, 1'b0);
    vec[11] = mk(OP_LOAD,    4'd11, 4'd0,  4'd0,  16'h0004, 16'h0004, 1'b0);
    vec[12] = mk(OP_MUL,     4'd12, 4'd10, 4'd11, 16'h0000, 16'h000C, 1'b0);
    vec[13] = mk(OP_ADDI,    4'd6,  4'd12, 4'd0,  16'h0010, 16'h001C, 1'b0);
    vec[14] = mk(OP_SUB,     4'd13, 4'd6,  4'd12, 16'h0000, 16'h0010, 1'b0);
    vec[15] = mk(OP_ADDI,    4'd14, 4'd3,  4'd0,  16'hFFFD, 16'h0001, 1'b1);
    vec[16] = mk(OP_LOAD,    4'd7,  4'd0,  4'd0,  16'hBEEF, 16'hBEEF, 1'b0);
    vec[17] = mk(OP_SUBI,    4'd15, 4'd1,  4'd0,  16'h0004, 16'hFFFF, 1'b1);
    vec[18] = mk(OP_DISPLAY, 4'd2,  4'd7,  4'd3,  16'h5555, 16'hBEEF, 1'b1);
    vec[19] = mk(OP_SUB,     4'd0,  4'd7,  4'd4,  16'h0000, 16'hBEED, 1'b0);
    vec[20] = mk(OP_CLEAR,   4'd1,  4'd2,  4'd3,  16'h7777, 16'hBEEF, 1'b0);
    vec[21] = mk(OP_DISPLAY, 4'd0,  4'd7,  4'd0,  16'h0000, 16'h0000, 1'b0);
    vec[22] = mk(OP_DISPLAY, 4'd0,  4'd3,  4'd0,  16'h0000, 16'h0000, 1'b0);
    vec[23] = mk(OP_LOAD,    4'd5,  4'd0,  4'd0,  16'h0055, 16'h0055, 1'b0);

    repeat (2) @(negedge clk);
    check("reset cmd_ready", bus.cmd_ready, 1'b1);
    check("reset mem_enable", bus.mem_enable, 1'b0);
    check("reset mem_clear", bus.mem_clear, 1'b0);
    check("reset pronto", bus.pronto, 1'b0);
    check("reset resultado", bus.resultado, 16'h0000);
    check("reset overflow", bus.overflow, 1'b0);
    check("reset read addr", {bus.mem_endereco_reg1, bus.mem_endereco_reg2}, 8'h00);
    ativar_clear_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      if (i == IDX_HOLD) hold_test();
      run_cmd(i, vec[i]);
    end

    reset_mid("rst_add", OP_ADD);
    run_cmd(100, mk(OP_DISPLAY, 4'd0, 4'd5, 4'd0, 16'h0000, 16'h0055, 1'b0));
    reset_mid("rst_clear", OP_CLEAR);
    run_cmd(101, mk(OP_DISPLAY, 4'd0, 4'd5, 4'd0, 16'h0000, 16'h0055, 1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/controle_memoria.md
Name: controle_memoria

Overview:
Command sequencer for the 16x16 register file. It accepts one arithmetic or housekeeping command at a time over a valid/ready handshake and drives the register file's two read addresses, its write port and its clear. It captures the read operands, computes the result, writes it back and pulses a completion flag. It sits between the command source (keypad/decoder front end) and the register file.

Parameters:
LARGURA, 16, data word width (register file word width)
ENDERECO, 4, register address width (2^ENDERECO registers)

Ports:
clk  input  1  system clock, rising edge
ativar_clear_n  input  1  asynchronous, active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command
opcode  input  3  operation code
rd  input  ENDERECO  destination register
rs1  input  ENDERECO  source register 1
rs2  input  ENDERECO  source register 2
imediato  input  LARGURA  immediate operand
mem_endereco_reg1  output  ENDERECO  register file read address 1
mem_endereco_reg2  output  ENDERECO  register file read address 2
mem_conteudo_reg1  input  LARGURA  register file read data 1 (asynchronous read)
mem_conteudo_reg2  input  LARGURA  register file read data 2 (asynchronous read)
mem_endereco_escrita  output  ENDERECO  register file write address
mem_conteudo_escrita  output  LARGURA  register file write data
mem_enable  output  1  register file write enable
mem_clear  output  1  register file clear request
resultado  output  LARGURA  last computed or displayed value
overflow  output  1  overflow flag of the last arithmetic command
pronto  output  1  one-cycle command-complete pulse

Behaviour:
- Reset (ativar_clear_n=0, asynchronous):
  - state OCIOSO.
  - All mem_* outputs 0; resultado 0; overflow 0; pronto 0.
  - cmd_ready = (state==OCIOSO), so it is 1 from reset onward.
  - Reset does not itself clear the register file.
- Handshake:
  - A command is accepted on a rising edge with cmd_valid && cmd_ready.
  - opcode, rd, rs1, rs2 and imediato are latched at accept; later input changes are ignored.
  - cmd_ready is 0 in every state except OCIOSO.
- Opcodes (all arithmetic unsigned, result truncated to LARGURA):
  - 000 LOAD: rd <= imediato.
  - 001 ADD: rd <= rs1+rs2.
  - 010 ADDI: rd <= rs1+imediato.
  - 011 SUB: rd <= rs1-rs2.
  - 100 SUBI: rd <= rs1-imediato.
  - 101 MUL: rd <= low LARGURA bits of rs1*rs2.
  - 110 CLEAR: clear the whole register file.
  - 111 DISPLAY: resultado <= rs1; no write.
- FSM states and transitions:
  - OCIOSO: on accept, go to LIMPA if CLEAR, else LEITURA.
  - LEITURA: mem_endereco_reg1=rs1, mem_endereco_reg2=rs2 (latched values). At the end edge, operands are captured into internal registers; go to EXECUTA.
  - EXECUTA: resultado and overflow are registered at the end edge. Go to FIM if DISPLAY, else ESCRITA.
  - ESCRITA: mem_enable=1, mem_endereco_escrita=rd, mem_conteudo_escrita=resultado, for exactly one cycle; then FIM.
  - LIMPA: mem_clear=1 for exactly one cycle; overflow cleared; resultado unchanged; then FIM.
  - FIM: pronto=1 for one cycle; then OCIOSO.
- Latency, counted from the accept edge to the pronto cycle:
  - LOAD/arithmetic: pronto in cycle 4.
  - DISPLAY: pronto in cycle 3.
  - CLEAR: pronto in cycle 2.
  - Back-to-back accept is possible in the cycle after pronto.
- mem_enable and mem_clear:
  - Both are registered (glitch-free) and are never high simultaneously.
  - Outside ESCRITA/LIMPA they are 0.
- Overflow rules:
  - ADD/ADDI: carry out of bit LARGURA-1.
  - SUB/SUBI: borrow (minuend < subtrahend).
  - MUL: upper product bits nonzero.
  - LOAD: overflow=0. DISPLAY: overflow unchanged.
- Hazards:
  - rd equal to rs1 or rs2 is legal: operands are captured before the write.
  - A command following a write to the same register reads the new value, because the write completes before OCIOSO.
- Reset mid-operation:
  - Immediate return to OCIOSO with all outputs at reset values.
  - No partial write or clear is issued after reset.
  - The in-flight command is dropped with no pronto.
- cmd_valid held high while busy is not re-accepted until OCIOSO.

Test Plan:
1. Reset; LOAD rd=3, imediato=0x1234 -> mem_enable high for exactly 1 cycle with addr 3, data 0x1234; pronto in cycle 4 after accept; resultado=0x1234; overflow=0.
2. r3=0xFFFF, r4=0x0002; ADD rd=5, rs1=3, rs2=4 -> write 0x0001 to addr 5; overflow=1. Then ADD rd=3, rs1=3, rs2=3 with r3=0x0002 -> writes 0x0004.
3. r1=3; SUBI rd=2, rs1=1, imediato=5 -> write 0xFFFE, overflow=1. Then MUL 0x0100*0x0100 -> write 0x0000, overflow=1; MUL 0x0003*0x0004 -> write 0x000C, overflow=0.
4. CLEAR -> mem_clear high exactly 1 cycle, mem_enable stays 0, pronto the next cycle, overflow=0. Subsequent DISPLAY of any register -> 0x0000.
5. r7=0xBEEF; DISPLAY rs1=7 -> resultado=0xBEEF, mem_enable never asserted, pronto in cycle 3. cmd_valid held high throughout -> exactly one accept per OCIOSO visit.
6. Assert ativar_clear_n=0 during LEITURA of an ADD, then during LIMPA of a CLEAR -> outputs go to 0 immediately, no mem_enable/mem_clear pulse, no pronto; cmd_ready=1 after release; target register keeps its old value.
